bpu_update_sched: RTL and testbench
===================================

# bpu_update_sched

Collects branch-resolution updates from multiple execute-stage branch units and feeds them, one per cycle, into the single training port of `branch_prediction_unit` (`ex_pc`, `ex_taken`, `ex_branch`, `ex_target_pc`). Same-cycle resolutions are buffered in a small in-order FIFO so no BTB or counter training is lost. Round-robin arbitration applies whenever free slots are scarcer than requests. Sits between the branch functional units and the BPU in the execute stage.

## Interface
- `NUM_REQ`, 2, number of branch-resolution requesters (2..4).
- `DEPTH`, 4, FIFO entries (power of two, at least `NUM_REQ`).
- `XLEN`, the global `` `XLEN`` macro; not a parameter.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; `0` clears all state immediately.
- `req_valid`  in  NUM_REQ  requester i holds a resolved branch.
- `req_pc`  in  NUM_REQ x XLEN  PC of the resolved branch.
- `req_taken`  in  NUM_REQ  resolved direction.
- `req_target_pc`  in  NUM_REQ x XLEN  resolved target.
- `req_ready`  out  NUM_REQ  requester i's update is accepted at this rising edge.
- `bpu_hold`  in  1  BPU cannot accept training this cycle (no dequeue).
- `bpu_ex_branch`  out  1  training update valid; drives BPU `ex_branch`.
- `bpu_ex_pc`  out  XLEN  drives BPU `ex_pc`.
- `bpu_ex_taken`  out  1  drives BPU `ex_taken`.
- `bpu_ex_target_pc`  out  XLEN  drives BPU `ex_target_pc`.
- `occupancy`  out  clog2(DEPTH+1)  current FIFO entry count.

## Operation
- Storage: circular FIFO of `{pc, taken, target_pc}` with head pointer, tail pointer and count.
- Free slots: `free = DEPTH - count`. A dequeue in the same cycle does not add to `free`; there is no bypass credit.
- Grant rule: scan requesters in round-robin order starting at `rr_ptr`. Grant each valid requester until `free` grants have been issued. `req_ready[i]` is combinational from `req_valid`, `count` and `rr_ptr`.
- Enqueue order: granted entries are written to `tail`, `tail+1`, … in scan order within the cycle.
- Round-robin pointer: `rr_ptr` advances to the requester after the last one granted, only when some valid requester was refused this cycle. Otherwise it is unchanged.
- Requester obligation: keep `req_valid` and the payload stable until `req_ready` is seen high.
- Dequeue: when `count > 0` and `bpu_hold == 0`:
  - `bpu_ex_branch = 1`;
  - the data outputs show the head entry;
  - head advances at the rising edge.
- Idle outputs: when the FIFO is empty or `bpu_hold == 1`, `bpu_ex_branch = 0` and the data outputs are 0.
- Count update: `count_next = count + grants - deq`. Pointers wrap modulo `DEPTH`.
- Overflow and underflow cannot occur by construction. An assertion checks `count <= DEPTH`.
- Reset (asynchronous, at any time, including mid-burst): the following go to 0, and buffered entries are discarded:
  - `count`, `head`, `tail`, `rr_ptr`;
  - `bpu_ex_branch`, `bpu_ex_pc`, `bpu_ex_taken`, `bpu_ex_target_pc`, `occupancy`;
  - `req_ready`.

## Timing
- Latency: an update accepted at edge k into an empty FIFO appears on the `bpu_ex_*` outputs during cycle k+1. The BPU trains on it at edge k+1.
- Throughput: at most one training update per cycle out; up to `min(NUM_REQ, free)` accepted per cycle in.
- Full FIFO: all `req_ready = 0` in that cycle, even if a dequeue happens in the same cycle. Requests resume the next cycle.
- `bpu_hold` asserted: the head is neither presented nor consumed, and occupancy holds or grows.
- Ordering: updates reach the BPU in acceptance order; same-cycle entries follow scan order from `rr_ptr`.
- Reset release: the first enqueue happens on the first rising edge with `reset == 1`.

## Structure
- Shared package `bpu_pkg`: `bpu_update_t` struct `{pc, taken, target_pc}`, plus the `DEPTH` and `NUM_REQ` defaults.
- Sub-module `rr_grant_n`: a combinational round-robin grant of up to K winners among N requesters. It returns the grant vector and the next `rr_ptr`.
- Top module: FIFO storage, pointers and count, and the output mux. The design is 150–250 lines.

## Test plan
- Single update:
  - Stimulus: reset, then `req_valid[0]`, pc=0x8000, taken=1, target=0x10.
  - Response: `req_ready[0] = 1`. In the next cycle `bpu_ex_branch = 1`, pc 0x8000, taken 1, target 0x10. In the cycle after, `bpu_ex_branch = 0`.
  - Hook the real BPU and confirm `predict_taken = 1` for pc 0x8000 afterwards.
- Simultaneous pair:
  - Stimulus: both requesters valid in one cycle (pcs 0x100, 0x200).
  - Response: both ready. The BPU sees 0x100 then 0x200 on consecutive cycles, and `occupancy` goes 2 → 1 → 0.
- Fill with hold:
  - Stimulus: `bpu_hold = 1`; push 2 per cycle for 3 cycles.
  - Response: cycles 1–2 accept 2 each, giving `occupancy = 4`. Cycle 3 gives `req_ready = 00`.
  - Then release hold: four updates drain in acceptance order, one per cycle.
- Round-robin fairness:
  - Stimulus: `occupancy = 3`, `DEPTH = 4`, both requesters valid; repeat while draining.
  - Response: the single grant alternates requester 0, 1, 0, … with no starvation over 8 cycles.
- Wrap-around:
  - Stimulus: 10 single updates with distinct pcs, interleaved with random `bpu_hold`.
  - Response: the output pc sequence matches the input sequence exactly across pointer wrap.
- Reset mid-operation:
  - Stimulus: `occupancy = 3`, then `reset` pulled low between edges.
  - Response: `bpu_ex_branch` and `occupancy` drop to 0 immediately. After release, no stale update is presented.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and default sizing for the branch-predictor training-update scheduler.
`ifndef XLEN
`define XLEN 32
`endif

package bpu_pkg;

  localparam int unsigned XLEN_W      = `XLEN;
  localparam int unsigned DEF_NUM_REQ = 2;
  localparam int unsigned DEF_DEPTH   = 4;

  // One resolved-branch training record as stored in the FIFO.
  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic              taken;
    logic [XLEN_W-1:0] target_pc;
  } bpu_update_t;

endpackage

// File: rtl/rr_grant_n.sv
// Combinational round-robin grant of up to `limit` winners among N requesters,
// reporting winners in scan order so the caller can enqueue them in that order.
module rr_grant_n #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1,
  parameter int unsigned CW = 3
) (
  input  logic [N-1:0]         req,
  input  logic [PW-1:0]        ptr,
  input  logic [CW-1:0]        limit,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         scan_grant,
  output logic [N-1:0][PW-1:0] scan_idx,
  output logic [CW-1:0]        num_grant,
  output logic [PW-1:0]        next_ptr
);

  localparam int unsigned SW = PW + 1;

  logic [SW-1:0] idx;
  logic [PW-1:0] after_last;
  logic          refused;

  always_comb begin
    grant      = '0;
    scan_grant = '0;
    scan_idx   = '0;
    num_grant  = '0;
    idx        = '0;
    after_last = ptr;
    refused    = 1'b0;
    for (int j = 0; j < N; j++) begin
      idx = SW'(ptr) + SW'(j);
      if (idx >= SW'(N)) idx = idx - SW'(N);
      scan_idx[j] = PW'(idx);
      if (req[PW'(idx)]) begin
        if (num_grant < limit) begin
          grant[PW'(idx)] = 1'b1;
          scan_grant[j]   = 1'b1;
          num_grant       = num_grant + CW'(1);
          after_last      = ((idx + SW'(1)) >= SW'(N)) ? '0 : PW'(idx + SW'(1));
        end else begin
          refused = 1'b1;
        end
      end
    end
    // Pointer only moves when someone lost this cycle and someone won.
    next_ptr = (refused && (num_grant != '0)) ? after_last : ptr;
  end

endmodule

// File: rtl/bpu_update_sched.sv
// Merges branch resolutions from several execute units into the BPU's single
// training port through a small in-order FIFO with round-robin admission.
`ifndef XLEN
`define XLEN 32
`endif

module bpu_update_sched
  import bpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][`XLEN-1:0]     req_pc,
  input  logic [NUM_REQ-1:0]                req_taken,
  input  logic [NUM_REQ-1:0][`XLEN-1:0]     req_target_pc,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              bpu_hold,
  output logic                              bpu_ex_branch,
  output logic [`XLEN-1:0]                  bpu_ex_pc,
  output logic                              bpu_ex_taken,
  output logic [`XLEN-1:0]                  bpu_ex_target_pc,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  bpu_update_t                mem [DEPTH];
  bpu_update_t                wr_data [DEPTH];
  bpu_update_t                head_entry;
  logic [DEPTH-1:0]           wr_en;
  logic [AW-1:0]              head;
  logic [AW-1:0]              tail;
  logic [AW-1:0]              wr_slot;
  logic [CW-1:0]              count;
  logic [CW-1:0]              free;
  logic [CW-1:0]              limit;
  logic [CW-1:0]              num_grant;
  logic [CW-1:0]              wr_off;
  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              rr_next;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         scan_grant;
  logic [NUM_REQ-1:0][PW-1:0] scan_idx;
  logic                       deq;

  // No credit for a same-cycle dequeue; nothing is admitted while in reset.
  assign free  = CW'(DEPTH) - count;
  assign limit = reset ? free : '0;

  rr_grant_n #(
    .N  (NUM_REQ),
    .PW (PW),
    .CW (CW)
  ) u_grant (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .limit      (limit),
    .grant      (grant),
    .scan_grant (scan_grant),
    .scan_idx   (scan_idx),
    .num_grant  (num_grant),
    .next_ptr   (rr_next)
  );

  assign req_ready = grant;

  // Place winners at tail, tail+1, ... in scan order.
  always_comb begin
    wr_en   = '0;
    wr_off  = '0;
    wr_slot = '0;
    for (int d = 0; d < DEPTH; d++) wr_data[d] = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (scan_grant[j]) begin
        wr_slot          = tail + AW'(wr_off);
        wr_en[wr_slot]   = 1'b1;
        wr_data[wr_slot] = '{pc:        req_pc[scan_idx[j]],
                             taken:     req_taken[scan_idx[j]],
                             target_pc: req_target_pc[scan_idx[j]]};
        wr_off           = wr_off + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int d = 0; d < DEPTH; d++) begin
      if (wr_en[d]) mem[d] <= wr_data[d];
    end
  end

  assign deq        = (count != '0) && !bpu_hold;
  assign head_entry = mem[head];

  // Training port shows the head only when it is actually being consumed.
  always_comb begin
    bpu_ex_branch    = deq;
    bpu_ex_pc        = '0;
    bpu_ex_taken     = 1'b0;
    bpu_ex_target_pc = '0;
    if (deq) begin
      bpu_ex_pc        = head_entry.pc;
      bpu_ex_taken     = head_entry.taken;
      bpu_ex_target_pc = head_entry.target_pc;
    end
  end

  assign occupancy = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      rr_ptr <= '0;
    end else begin
      count  <= count + num_grant - CW'(deq);
      head   <= head + AW'(deq);
      tail   <= tail + AW'(num_grant);
      rr_ptr <= rr_next;
    end
  end

  a_count_bound : assert property (@(posedge clock) disable iff (!reset)
    count <= CW'(DEPTH));

endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed vector bench for bpu_update_sched (NUM_REQ=2, DEPTH=4).
module tb_bpu_update_sched;
  import bpu_pkg::*;

  localparam int unsigned XW = XLEN_W;
  localparam logic [XW-1:0] TGT_MASK = XW'(32'h0000_8010);

  logic                clock;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0][XW-1:0]  req_pc;
  logic [1:0]          req_taken;
  logic [1:0][XW-1:0]  req_target_pc;
  logic [1:0]          req_ready;
  logic                bpu_hold;
  logic                bpu_ex_branch;
  logic [XW-1:0]       bpu_ex_pc;
  logic                bpu_ex_taken;
  logic [XW-1:0]       bpu_ex_target_pc;
  logic [2:0]          occupancy;

  int checks = 0;
  int errors = 0;

  bpu_update_sched #(.NUM_REQ(2), .DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_pc           (req_pc),
    .req_taken        (req_taken),
    .req_target_pc    (req_target_pc),
    .req_ready        (req_ready),
    .bpu_hold         (bpu_hold),
    .bpu_ex_branch    (bpu_ex_branch),
    .bpu_ex_pc        (bpu_ex_pc),
    .bpu_ex_taken     (bpu_ex_taken),
    .bpu_ex_target_pc (bpu_ex_target_pc),
    .occupancy        (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          hold;
    logic [1:0]    valid;
    logic [XW-1:0] pc0;
    logic [XW-1:0] pc1;
    logic [1:0]    tk;
    logic [1:0]    exp_ready;
    logic          exp_branch;
    logic [XW-1:0] exp_pc;
    logic          exp_taken;
    logic [2:0]    exp_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic h, input logic [1:0] v, input logic [31:0] p0,
                              input logic [31:0] p1, input logic [1:0] tk,
                              input logic [1:0] er, input logic eb, input logic [31:0] ep,
                              input logic et, input logic [2:0] eo);
    vec_t x;
    x.hold = h; x.valid = v; x.pc0 = XW'(p0); x.pc1 = XW'(p1); x.tk = tk;
    x.exp_ready = er; x.exp_branch = eb; x.exp_pc = XW'(ep); x.exp_taken = et; x.exp_occ = eo;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [1:0] v, input logic [XW-1:0] p0,
                       input logic [XW-1:0] p1, input logic [1:0] tk);
    bpu_hold         = h;
    req_valid        = v;
    req_pc[0]        = p0;
    req_pc[1]        = p1;
    req_taken        = tk;
    req_target_pc[0] = p0 ^ TGT_MASK;
    req_target_pc[1] = p1 ^ TGT_MASK;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         v;
    logic [XW-1:0] sb[$];
    logic [XW-1:0] wpc;
    logic         h;
    logic         exp_rdy;
    logic         exp_br;
    int           sent;
    int           got;

    // Single update, then simultaneous pair
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 0, 0,       0, 0);
    add(0, 2'b01, 'h8000,  0,       2'b01, 2'b01, 0, 0,       0, 0);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 1, 'h8000,  1, 1);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 0, 0,       0, 0);
    add(0, 2'b11, 'h100,   'h200,   2'b10, 2'b11, 0, 0,       0, 0);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 1, 'h100,   0, 2);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 1, 'h200,   1, 1);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 0, 0,       0, 0);
    // Fill under hold, full FIFO refuses even with a dequeue
    add(1, 2'b11, 'h300,   'h304,   2'b10, 2'b11, 0, 0,       0, 0);
    add(1, 2'b11, 'h308,   'h30c,   2'b10, 2'b11, 0, 0,       0, 2);
    add(1, 2'b11, 'h310,   'h314,   2'b10, 2'b00, 0, 0,       0, 4);
    add(0, 2'b11, 'h310,   'h314,   2'b10, 2'b00, 1, 'h300,   0, 4);
    // Round-robin alternation at occupancy 3 while draining
    add(0, 2'b11, 'h310,   'h314,   2'b10, 2'b01, 1, 'h304,   1, 3);
    add(0, 2'b11, 'h318,   'h314,   2'b10, 2'b10, 1, 'h308,   0, 3);
    add(0, 2'b11, 'h318,   'h31c,   2'b10, 2'b01, 1, 'h30c,   1, 3);
    add(0, 2'b11, 'h320,   'h31c,   2'b10, 2'b10, 1, 'h310,   0, 3);
    add(0, 2'b11, 'h320,   'h324,   2'b10, 2'b01, 1, 'h314,   1, 3);
    add(0, 2'b11, 'h328,   'h324,   2'b10, 2'b10, 1, 'h318,   0, 3);
    add(0, 2'b11, 'h328,   'h32c,   2'b10, 2'b01, 1, 'h31c,   1, 3);
    add(0, 2'b11, 'h330,   'h32c,   2'b10, 2'b10, 1, 'h320,   0, 3);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 1, 'h324,   1, 3);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 1, 'h328,   0, 2);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 1, 'h32c,   1, 1);
    add(0, 2'b00, 0,       0,       2'b00, 2'b00, 0, 0,       0, 0);

    // Reset with requests pending: nothing may be accepted
    reset = 1'b0;
    drive(0, 2'b11, XW'(32'h40), XW'(32'h44), 2'b11);
    repeat (2) @(negedge clock);
    #1;
    chk("reset ready", 64'(req_ready), 64'(2'b00));
    chk("reset branch", 64'(bpu_ex_branch), 64'(1'b0));
    chk("reset occupancy", 64'(occupancy), 64'(3'd0));
    chk("reset pc", 64'(bpu_ex_pc), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    drive(0, 2'b00, '0, '0, 2'b00);

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clock);
      drive(v.hold, v.valid, v.pc0, v.pc1, v.tk);
      #1;
      chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(v.exp_ready));
      chk($sformatf("v%0d branch", i), 64'(bpu_ex_branch), 64'(v.exp_branch));
      chk($sformatf("v%0d pc", i), 64'(bpu_ex_pc), 64'(v.exp_branch ? v.exp_pc : '0));
      chk($sformatf("v%0d taken", i), 64'(bpu_ex_taken), 64'(v.exp_branch & v.exp_taken));
      chk($sformatf("v%0d target", i), 64'(bpu_ex_target_pc),
          64'(v.exp_branch ? (v.exp_pc ^ TGT_MASK) : '0));
      chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(v.exp_occ));
    end

    // Wrap-around: ten single updates with random hold, order checked by scoreboard
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(negedge clock);
      h   = 1'($urandom_range(0, 1));
      wpc = XW'(32'h1000 + 32'(sent) * 32'h40);
      drive(h, (sent < 10) ? 2'b01 : 2'b00, wpc, '0, 2'b00);
      exp_rdy = (sent < 10) && (sb.size() < 4);
      exp_br  = (sb.size() != 0) && !h;
      #1;
      chk($sformatf("wrap c%0d ready", cyc), 64'(req_ready), 64'({1'b0, exp_rdy}));
      chk($sformatf("wrap c%0d branch", cyc), 64'(bpu_ex_branch), 64'(exp_br));
      if (exp_br) begin
        chk($sformatf("wrap c%0d pc", cyc), 64'(bpu_ex_pc), 64'(sb[0]));
        void'(sb.pop_front());
        got++;
      end
      if (exp_rdy) begin
        sb.push_back(wpc);
        sent++;
      end
    end
    chk("wrap delivered count", 64'(got), 64'(10));

    // Reset mid-operation with three entries buffered
    @(negedge clock);
    drive(1, 2'b11, XW'(32'h500), XW'(32'h504), 2'b00);
    #1;
    chk("mid fill ready a", 64'(req_ready), 64'(2'b11));
    @(negedge clock);
    drive(1, 2'b01, XW'(32'h508), '0, 2'b00);
    #1;
    chk("mid fill ready b", 64'(req_ready), 64'(2'b01));
    @(negedge clock);
    drive(0, 2'b00, '0, '0, 2'b00);
    #1;
    chk("mid occupancy pre", 64'(occupancy), 64'(3'd3));
    chk("mid pc pre", 64'(bpu_ex_pc), 64'(32'h500));
    #1;
    reset = 1'b0;
    drive(0, 2'b01, XW'(32'h600), '0, 2'b01);
    #1;
    chk("mid reset branch", 64'(bpu_ex_branch), 64'(1'b0));
    chk("mid reset occupancy", 64'(occupancy), 64'(3'd0));
    chk("mid reset ready", 64'(req_ready), 64'(2'b00));
    #1;
    reset = 1'b1;
    @(negedge clock);
    drive(0, 2'b00, '0, '0, 2'b00);
    #1;
    chk("post reset branch", 64'(bpu_ex_branch), 64'(1'b1));
    chk("post reset pc", 64'(bpu_ex_pc), 64'(32'h600));
    chk("post reset occupancy", 64'(occupancy), 64'(3'd1));
    @(negedge clock);
    #1;
    chk("post reset drained", 64'(bpu_ex_branch), 64'(1'b0));
    chk("post reset empty", 64'(occupancy), 64'(3'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
